// File: rtl/epu_pipe_pkg.sv
// Shared definitions for EPU inter-stage pipeline registers.
//   - EX/MEM payload field widths and bit offsets (packed MSB->LSB:
//     forward, rd_addr, rd_val, ins_type, ins_details, mem_addr, mem_val).
//   - Skid slot occupancy states.
//   - A NOP payload encoding (ins_type = ADDI) usable as a reset value.
package epu_pipe_pkg;

  localparam int FWD_W      = 1;
  localparam int RD_ADDR_W  = 5;
  localparam int WORD_W     = 32;
  localparam int INS_TYPE_W = 7;
  localparam int INS_DET_W  = 3;

  localparam int EX_MEM_W = FWD_W + RD_ADDR_W + WORD_W + INS_TYPE_W
                          + INS_DET_W + WORD_W + WORD_W;  // 112

  localparam int MEM_VAL_LSB  = 0;
  localparam int MEM_ADDR_LSB = MEM_VAL_LSB + WORD_W;
  localparam int INS_DET_LSB  = MEM_ADDR_LSB + WORD_W;
  localparam int INS_TYPE_LSB = INS_DET_LSB + INS_DET_W;
  localparam int RD_VAL_LSB   = INS_TYPE_LSB + INS_TYPE_W;
  localparam int RD_ADDR_LSB  = RD_VAL_LSB + WORD_W;
  localparam int FWD_LSB      = RD_ADDR_LSB + RD_ADDR_W;

  localparam logic [INS_TYPE_W-1:0] INS_TYPE_ADDI = 7'b0010011;

  // ADDI x0,x0,0 with every other field zero: a harmless bubble.
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP =
    EX_MEM_W'(INS_TYPE_ADDI) << INS_TYPE_LSB;

  // Slot occupancy: EMPTY (main invalid), ONE (main valid), TWO (main+skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One two-entry skid register with valid/ready handshake.
// Ports:
//   clk_in, rst_in (sync, active-low)
//   flush      : empty the slot at the next edge
//   rdy        : global enable; 0 blocks both transfers
//   in_valid/in_ready/in_data    : upstream side (in_ready is a pure
//                                  function of slot state, no ready path)
//   out_valid/out_ready/out_data : downstream side, from the main register
//   valid_cnt  : number of valid entries held (0..2)
module pipe_skid_slot
  import epu_pipe_pkg::*;
#(
  parameter int                DATA_W  = EX_MEM_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush,
  input  logic              rdy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        valid_cnt
);

  slot_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, main_from_skid;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready & rdy;
  assign out_fire  = out_valid & out_ready & rdy;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    valid_cnt      = 2'd0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        valid_cnt = 2'd1;
        if (in_fire && !out_fire) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_d = EMPTY;
        end else if (in_fire && out_fire) begin
          load_main = 1'b1;
        end
      end
      TWO: begin
        valid_cnt = 2'd2;
        // in_ready is low here, so only the drain can happen.
        if (out_fire) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush) begin
      main_data <= RST_VAL;
      skid_data <= RST_VAL;
    end else begin
      if (load_main) begin
        main_data <= in_data;
      end else if (main_from_skid) begin
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_skid_chain.sv
// Parametrised inter-stage pipeline register: DEPTH skid slots in series.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global enable), flush_in
//   up_valid/up_ready/up_data : producer side; up_ready has no path from dn_ready
//   dn_valid/dn_ready/dn_data : consumer side, straight from the last slot
//   occupancy                 : total valid entries across all slots
module pipe_skid_chain
  import epu_pipe_pkg::*;
#(
  parameter int                DATA_W  = EX_MEM_W,
  parameter int                DEPTH   = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               OCC_W   = $clog2(2*DEPTH+1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [OCC_W-1:0]  occupancy
);

  // Link k feeds slot k; link DEPTH is the consumer side.
  logic [DEPTH:0]    link_valid;
  logic [DEPTH:0]    link_ready;
  logic [DATA_W-1:0] link_data [DEPTH+1];
  logic [1:0]        slot_cnt  [DEPTH];

  assign link_valid[0]     = up_valid;
  assign link_data[0]      = up_data;
  assign up_ready          = link_ready[0];
  assign link_ready[DEPTH] = dn_ready;
  assign dn_valid          = link_valid[DEPTH];
  assign dn_data           = link_data[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_skid_slot #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_slot (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .flush     (flush_in),
      .rdy       (rdy_in),
      .in_valid  (link_valid[k]),
      .in_ready  (link_ready[k]),
      .in_data   (link_data[k]),
      .out_valid (link_valid[k+1]),
      .out_ready (link_ready[k+1]),
      .out_data  (link_data[k+1]),
      .valid_cnt (slot_cnt[k])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(slot_cnt[k]);
    end
  end

endmodule

// File: tb/tb_pipe_skid_chain.sv
module tb_pipe_skid_chain;

  localparam int          DW  = 16;
  localparam logic [15:0] RST = 16'h0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rdy, flush, up_valid, dn_ready;
  logic [DW-1:0] up_data;

  logic d1_up_ready, d1_dn_valid, d2_up_ready, d2_dn_valid, d3_up_ready, d3_dn_valid;
  logic [DW-1:0] d1_dn_data, d2_dn_data, d3_dn_data;
  logic [1:0] d1_occ;
  logic [2:0] d2_occ, d3_occ;

  pipe_skid_chain #(.DATA_W(DW), .DEPTH(1), .RST_VAL(RST)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .up_valid(up_valid), .up_ready(d1_up_ready), .up_data(up_data),
    .dn_valid(d1_dn_valid), .dn_ready(dn_ready), .dn_data(d1_dn_data),
    .occupancy(d1_occ));

  pipe_skid_chain #(.DATA_W(DW), .DEPTH(2), .RST_VAL(RST)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .up_valid(up_valid), .up_ready(d2_up_ready), .up_data(up_data),
    .dn_valid(d2_dn_valid), .dn_ready(dn_ready), .dn_data(d2_dn_data),
    .occupancy(d2_occ));

  pipe_skid_chain #(.DATA_W(DW), .DEPTH(3), .RST_VAL(RST)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .up_valid(up_valid), .up_ready(d3_up_ready), .up_data(up_data),
    .dn_valid(d3_dn_valid), .dn_ready(dn_ready), .dn_data(d3_dn_data),
    .occupancy(d3_occ));

  int total = 0;
  int bad   = 0;

  // Accepted and delivered beats per chain, in the order they crossed.
  logic [DW-1:0] in1[$], out1[$], in2[$], out2[$], in3[$], out3[$];

  task automatic clear_logs();
    in1.delete(); out1.delete(); in2.delete();
    out2.delete(); in3.delete(); out3.delete();
  endtask

  // Record every handshake that takes effect at the coming edge, then
  // advance to 1 time unit after that edge.
  task automatic tick();
    if (rst_n && rdy && !flush) begin
      if (up_valid && d1_up_ready) in1.push_back(up_data);
      if (up_valid && d2_up_ready) in2.push_back(up_data);
      if (up_valid && d3_up_ready) in3.push_back(up_data);
      if (d1_dn_valid && dn_ready) out1.push_back(d1_dn_data);
      if (d2_dn_valid && dn_ready) out2.push_back(d2_dn_data);
      if (d3_dn_valid && dn_ready) out3.push_back(d3_dn_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    up_valid = 1'b1; up_data = 16'h1234; dn_ready = 1'b1;
    tick(); tick();
    total += 12;
    if (d1_dn_valid !== 1'b0) begin bad++; $display("FAIL reset_dn_valid_d1 got=%b want=0", d1_dn_valid); end
    if (d2_dn_valid !== 1'b0) begin bad++; $display("FAIL reset_dn_valid_d2 got=%b want=0", d2_dn_valid); end
    if (d3_dn_valid !== 1'b0) begin bad++; $display("FAIL reset_dn_valid_d3 got=%b want=0", d3_dn_valid); end
    if (d1_up_ready !== 1'b1) begin bad++; $display("FAIL reset_up_ready_d1 got=%b want=1", d1_up_ready); end
    if (d2_up_ready !== 1'b1) begin bad++; $display("FAIL reset_up_ready_d2 got=%b want=1", d2_up_ready); end
    if (d3_up_ready !== 1'b1) begin bad++; $display("FAIL reset_up_ready_d3 got=%b want=1", d3_up_ready); end
    if (d1_occ !== 2'd0) begin bad++; $display("FAIL reset_occ_d1 got=%0d want=0", d1_occ); end
    if (d2_occ !== 3'd0) begin bad++; $display("FAIL reset_occ_d2 got=%0d want=0", d2_occ); end
    if (d3_occ !== 3'd0) begin bad++; $display("FAIL reset_occ_d3 got=%0d want=0", d3_occ); end
    if (d1_dn_data !== RST) begin bad++; $display("FAIL reset_data_d1 got=%h want=%h", d1_dn_data, RST); end
    if (d2_dn_data !== RST) begin bad++; $display("FAIL reset_data_d2 got=%h want=%h", d2_dn_data, RST); end
    if (d3_dn_data !== RST) begin bad++; $display("FAIL reset_data_d3 got=%h want=%h", d3_dn_data, RST); end
    rst_n = 1'b1; up_valid = 1'b0;
    clear_logs();
  endtask

  // DEPTH=2: 16 back-to-back beats with the consumer always ready.
  task automatic test_stream();
    int first_in = -1, first_out = -1, gaps = 0, stalls = 0;
    apply_reset();
    dn_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      up_valid = (i < 16);
      up_data  = DW'(i);
      if (i < 16 && !d2_up_ready) stalls++;
      if (first_in < 0 && up_valid && d2_up_ready) first_in = i;
      tick();
      if (first_out < 0 && d2_dn_valid) first_out = i;
      if (first_out >= 0 && out2.size() < 16 && !d2_dn_valid) gaps++;
    end
    up_valid = 1'b0;
    total += 4;
    if (first_out - first_in !== 1) begin bad++; $display("FAIL stream_latency got=%0d want=1 edges", first_out - first_in); end
    if (gaps !== 0) begin bad++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
    if (stalls !== 0) begin bad++; $display("FAIL stream_up_stalls got=%0d want=0", stalls); end
    if (out2.size() !== 16) begin bad++; $display("FAIL stream_count got=%0d want=16", out2.size()); end
    for (int i = 0; i < 16 && i < out2.size(); i++) begin
      total++;
      if (out2[i] !== DW'(i)) begin bad++; $display("FAIL stream_beat%0d got=%h want=%h", i, out2[i], DW'(i)); end
    end
  endtask

  // DEPTH=1: consumer stalled while A,B,C are offered, then released.
  task automatic test_backpressure();
    logic [DW-1:0] exp[3];
    exp[0] = 16'hA0A0; exp[1] = 16'hB1B1; exp[2] = 16'hC2C2;
    apply_reset();
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = exp[0]; tick();
    up_data = exp[1]; tick();
    total += 2;
    if (d1_up_ready !== 1'b0) begin bad++; $display("FAIL bp_up_ready_after_b got=%b want=0", d1_up_ready); end
    if (d1_occ !== 2'd2) begin bad++; $display("FAIL bp_occ_full got=%0d want=2", d1_occ); end
    up_data = exp[2]; tick(); tick();
    total += 3;
    if (in1.size() !== 2) begin bad++; $display("FAIL bp_c_held got=%0d accepted want=2", in1.size()); end
    if (d1_occ !== 2'd2) begin bad++; $display("FAIL bp_occ_hold got=%0d want=2", d1_occ); end
    if (d1_dn_data !== exp[0]) begin bad++; $display("FAIL bp_head got=%h want=%h", d1_dn_data, exp[0]); end
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (in1.size() == 3) up_valid = 1'b0;
      tick();
    end
    up_valid = 1'b0;
    total++;
    if (out1.size() !== 3) begin bad++; $display("FAIL bp_drain_count got=%0d want=3 in 3 cycles", out1.size()); end
    for (int i = 0; i < 3 && i < out1.size(); i++) begin
      total++;
      if (out1[i] !== exp[i]) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, out1[i], exp[i]); end
    end
  endtask

  // DEPTH=2: fill to 3, flush while 0xDEAD is offered.
  task automatic test_flush();
    int guard = 0;
    apply_reset();
    dn_ready = 1'b0; up_valid = 1'b1;
    while (d2_occ != 3'd3 && guard < 20) begin
      up_data = DW'(16'h0100 + in2.size());
      tick();
      guard++;
    end
    total++;
    if (d2_occ !== 3'd3) begin bad++; $display("FAIL flush_fill got=%0d want=3", d2_occ); end
    flush = 1'b1; up_data = 16'hDEAD; dn_ready = 1'b1;
    tick();
    flush = 1'b0; up_valid = 1'b0;
    total += 4;
    if (d2_occ !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", d2_occ); end
    if (d2_dn_valid !== 1'b0) begin bad++; $display("FAIL flush_dn_valid got=%b want=0", d2_dn_valid); end
    if (d2_up_ready !== 1'b1) begin bad++; $display("FAIL flush_up_ready got=%b want=1", d2_up_ready); end
    if (d2_dn_data !== RST) begin bad++; $display("FAIL flush_data got=%h want=%h", d2_dn_data, RST); end
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (out2.size() !== 0) begin bad++; $display("FAIL flush_no_output got=%0d beats want=0", out2.size()); end
    foreach (out2[i]) begin
      total++;
      if (out2[i] === 16'hDEAD) begin bad++; $display("FAIL flush_dead_leak got=%h want=not DEAD", out2[i]); end
    end
  endtask

  // DEPTH=2: global enable dropped for 5 cycles mid-stream.
  task automatic test_stall();
    logic [DW-1:0] held_data;
    logic [2:0]    held_occ;
    logic          held_vld;
    int            guard = 0;
    apply_reset();
    dn_ready = 1'b1; up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_data = DW'(100 + in2.size());
      tick();
    end
    rdy = 1'b0;
    held_data = d2_dn_data; held_occ = d2_occ; held_vld = d2_dn_valid;
    for (int i = 0; i < 5; i++) begin
      up_data = DW'(100 + in2.size());
      tick();
      total += 3;
      if (d2_dn_data !== held_data) begin bad++; $display("FAIL stall_data_c%0d got=%h want=%h", i, d2_dn_data, held_data); end
      if (d2_occ !== held_occ) begin bad++; $display("FAIL stall_occ_c%0d got=%0d want=%0d", i, d2_occ, held_occ); end
      if (d2_dn_valid !== held_vld) begin bad++; $display("FAIL stall_vld_c%0d got=%b want=%b", i, d2_dn_valid, held_vld); end
    end
    rdy = 1'b1;
    while (in2.size() < 20 && guard < 50) begin
      up_data = DW'(100 + in2.size());
      tick();
      guard++;
    end
    up_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (out2.size() !== 20) begin bad++; $display("FAIL stall_count got=%0d want=20", out2.size()); end
    for (int i = 0; i < 20 && i < out2.size(); i++) begin
      total++;
      if (out2[i] !== DW'(100 + i)) begin bad++; $display("FAIL stall_beat%0d got=%h want=%h", i, out2[i], DW'(100 + i)); end
    end
  endtask

  // DEPTH=3: random valid/ready/enable, 1000 beats against a FIFO model.
  task automatic test_random();
    int guard = 0;
    logic ur;
    apply_reset();
    while (in3.size() < 1000 && guard < 20000) begin
      up_valid = ($urandom_range(3) != 0);
      up_data  = DW'($urandom);
      rdy      = ($urandom_range(7) != 0);
      dn_ready = 1'b0;
      #1;
      ur = d3_up_ready;
      dn_ready = 1'b1;
      #1;
      total++;
      if (d3_up_ready !== ur) begin bad++; $display("FAIL rand_ready_path got=%b want=%b", d3_up_ready, ur); end
      dn_ready = ($urandom_range(2) != 0);
      tick();
      guard++;
      total += 2;
      if (32'(d3_occ) !== in3.size() - out3.size()) begin
        bad++; $display("FAIL rand_occ got=%0d want=%0d", d3_occ, in3.size() - out3.size());
      end
      if (d3_occ > 3'd6) begin bad++; $display("FAIL rand_occ_max got=%0d want<=6", d3_occ); end
    end
    up_valid = 1'b0; rdy = 1'b1; dn_ready = 1'b1;
    guard = 0;
    while (out3.size() < in3.size() && guard < 50) begin
      tick();
      guard++;
    end
    total += 2;
    if (in3.size() < 1000) begin bad++; $display("FAIL rand_sent got=%0d want=1000", in3.size()); end
    if (out3.size() !== in3.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", out3.size(), in3.size()); end
    for (int i = 0; i < in3.size() && i < out3.size(); i++) begin
      total++;
      if (out3[i] !== in3[i]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", i, out3[i], in3[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
